product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter WIDTH_IN, default 18, SHALL be the signed input width, matching the upstream multiplier product width.
REQ-002 Parameter WIDTH_ACC, default 24, SHALL be the signed accumulator and output width; WIDTH_ACC >= WIDTH_IN.
REQ-003 Parameter NUM_TERMS, default 16, SHALL be the number of products summed per result; NUM_TERMS >= 1.
REQ-004 Port list (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data holds a valid two's-complement product.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH_IN  signed product from the multiplier stage.
- out_valid  out  1  out_data holds a completed sum.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH_ACC  signed sum of NUM_TERMS products.
- out_overflow  out  1  at least one signed overflow occurred in this sum.

Function
REQ-005 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-006 The block SHALL use three states: IDLE, ACCUM and DONE.
REQ-007 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DONE, and 0 while rst_n=0.
REQ-008 IDLE SHALL respond to an input transfer as follows:
- acc := sign-extended in_data; count := 1.
- Next state: DONE if NUM_TERMS=1, otherwise ACCUM.
REQ-009 ACCUM SHALL respond to an input transfer as follows:
- acc := acc + sign-extended in_data; count := count + 1.
- Next state: DONE once count reaches NUM_TERMS.
REQ-010 Cycles with in_valid=0 SHALL leave acc, count and state unchanged; bubbles are allowed anywhere in a sum.
REQ-011 On entering DONE, the following SHALL hold:
- out_valid=1 in the cycle after the NUM_TERMS-th input transfer (latency 1).
- out_data = final acc.
- out_overflow = the sticky overflow flag.
REQ-012 In DONE, out_valid, out_data and out_overflow SHALL stay stable until an output transfer.
REQ-013 An output transfer SHALL do the following on the same edge:
- Next state: IDLE.
- out_valid := 0.
- acc, count and the overflow flag cleared.
- The next cycle has in_ready=1.
REQ-014 No input transfer SHALL be possible in the cycle of an output transfer (in_ready=0 in DONE).
REQ-015 Signed overflow SHALL be detected on every addition:
- Condition: both operands have the same sign and the result sign differs.
- The overflow flag SHALL be set and remain sticky until cleared per REQ-013 or reset.
REQ-016 count SHALL be ceil(log2(NUM_TERMS+1)) bits wide and SHALL never exceed NUM_TERMS.
REQ-017 out_data SHALL read 0 whenever out_valid=0.

Reset
REQ-018 On a rising edge with rst_n=0, the following SHALL be forced:
- state := IDLE.
- acc, count, out_data, out_overflow := 0.
- out_valid := 0.
REQ-019 A reset mid-ACCUM or mid-DONE SHALL discard the partial or pending sum with no output transfer; the first transfer after reset starts a fresh sum.

Configuration
REQ-020 Macro PRODUCT_ACCUMULATOR_SATURATE_EN SHALL select the overflow behaviour:
- Defined: an overflowing addition clamps acc to 2^(WIDTH_ACC-1)-1 (positive) or -2^(WIDTH_ACC-1) (negative); later additions continue from the clamped value.
- Undefined: acc wraps modulo 2^WIDTH_ACC.
- out_overflow behaviour is identical in both builds.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- NUM_TERMS=4: inputs 100, -30, 7, 1 back-to-back -> out_valid one cycle after the 4th; out_data=78; out_overflow=0.
- NUM_TERMS=4: same inputs with 3 idle cycles between samples -> out_data=78; out_valid one cycle after the 4th transfer.
- out_ready held 0 for 5 cycles in DONE -> out_data/out_valid stable and in_ready=0; after the handshake, IDLE with in_ready=1 next cycle.
- WIDTH_ACC=20, NUM_TERMS=8: eight inputs of 131071 -> saturate build out_data=524287; wrap build out_data=-8; out_overflow=1 in both.
- NUM_TERMS=4: rst_n=0 for one edge after 2 samples, then inputs 5, 5, 5, 5 -> out_data=20; no output before the 4th post-reset transfer.
- NUM_TERMS=1: input -42 -> out_valid next cycle with out_data=-42; in_ready=0 until the output is accepted.

Source files
------------

// File: rtl/product_accumulator.sv
// Signed product accumulator: sums NUM_TERMS products, then holds the result until accepted.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int WIDTH_IN  = 18,
  parameter int WIDTH_ACC = 24,
  parameter int NUM_TERMS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_IN-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_ACC-1:0] out_data,
  output logic                        out_overflow
);

  localparam int CNT_W = $clog2(NUM_TERMS + 1);
  localparam logic signed [WIDTH_ACC-1:0] ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
  localparam logic signed [WIDTH_ACC-1:0] ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e                        state_q, state_d;
  logic signed [WIDTH_ACC-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          ovf_q, ovf_d;

  logic signed [WIDTH_ACC-1:0]   in_ext;
  logic signed [WIDTH_ACC-1:0]   sum;
  logic signed [WIDTH_ACC-1:0]   acc_add;
  logic                          add_ovf;
  logic                          in_fire;

  assign in_ext  = WIDTH_ACC'(in_data);
  assign sum     = acc_q + in_ext;
  // Same-sign operands producing an opposite-sign result is the only way a signed add overflows.
  assign add_ovf = (acc_q[WIDTH_ACC-1] == in_ext[WIDTH_ACC-1]) &&
                   (sum[WIDTH_ACC-1] != acc_q[WIDTH_ACC-1]);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  assign acc_add = add_ovf ? (acc_q[WIDTH_ACC-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_add = sum;
`endif

  assign in_ready     = rst_n && (state_q != DONE);
  assign in_fire      = in_valid && in_ready;
  assign out_valid    = (state_q == DONE);
  assign out_data     = out_valid ? acc_q : '0;
  assign out_overflow = out_valid && ovf_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          acc_d   = in_ext;
          count_d = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (NUM_TERMS == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_d   = acc_add;
          count_d = count_q + CNT_W'(1);
          ovf_d   = ovf_q | add_ovf;
          if (count_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: three accumulator configurations against a per-term arithmetic model.
module tb_product_accumulator;

  localparam int NDUT = 3;
  localparam int NT[NDUT] = '{4, 1, 8};
  localparam int WA[NDUT] = '{24, 24, 20};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               iv[NDUT];
  logic               ir[NDUT];
  logic signed [17:0] id[NDUT];
  logic               ov[NDUT];
  logic               ordy[NDUT];
  logic               ovf[NDUT];
  logic signed [23:0] od0, od1;
  logic signed [19:0] od2;

  product_accumulator #(.WIDTH_IN(18), .WIDTH_ACC(24), .NUM_TERMS(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .out_overflow(ovf[0]));
  product_accumulator #(.WIDTH_IN(18), .WIDTH_ACC(24), .NUM_TERMS(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .out_overflow(ovf[1]));
  product_accumulator #(.WIDTH_IN(18), .WIDTH_ACC(20), .NUM_TERMS(8)) u_n8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .out_overflow(ovf[2]));

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a list of accepted terms folded with plain integer arithmetic per addition.
  bit     m_done[NDUT];
  int     m_cnt[NDUT];
  longint m_acc[NDUT];
  bit     m_ovf[NDUT];

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      m_done[k] = 1'b0; m_cnt[k] = 0; m_acc[k] = 0; m_ovf[k] = 1'b0;
      iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b0;
    end
  end

  function automatic longint fold(input int k, input longint a, input longint x, inout bit o);
    longint s, mx, mn;
    s  = a + x;
    mx = (longint'(1) <<< (WA[k] - 1)) - 1;
    mn = -mx - 1;
    if (s > mx || s < mn) begin
      o = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      s = (s > mx) ? mx : mn;
`else
      s = (s > mx) ? s - (longint'(1) <<< WA[k]) : s + (longint'(1) <<< WA[k]);
`endif
    end
    return s;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      automatic bit     d = m_done[k];
      automatic int     c = m_cnt[k];
      automatic longint a = m_acc[k];
      automatic bit     o = m_ovf[k];
      if (!rst_n) begin
        d = 0; c = 0; a = 0; o = 0;
      end else if (d) begin
        if (ordy[k]) begin d = 0; c = 0; a = 0; o = 0; end
      end else if (iv[k]) begin
        if (c == 0) begin a = longint'(id[k]); o = 0; end
        else a = fold(k, a, longint'(id[k]), o);
        c++;
        if (c == NT[k]) d = 1;
      end
      m_done[k] <= d; m_cnt[k] <= c; m_acc[k] <= a; m_ovf[k] <= o;
    end
  end

  function automatic longint dut_data(input int k);
    case (k)
      0:       return longint'(od0);
      1:       return longint'(od1);
      default: return longint'(od2);
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("in_ready[%0d]", k), longint'(ir[k]), longint'(rst_n && !m_done[k]));
        check($sformatf("out_valid[%0d]", k), longint'(ov[k]), longint'(m_done[k]));
        check($sformatf("out_data[%0d]", k), dut_data(k), m_done[k] ? m_acc[k] : 0);
        if (m_done[k]) check($sformatf("out_overflow[%0d]", k), longint'(ovf[k]), longint'(m_ovf[k]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int k, input int val);
    iv[k] = 1'b1; id[k] = 18'(val);
    tick(1);
    iv[k] = 1'b0;
  endtask

  task automatic accept(input int k);
    ordy[k] = 1'b1;
    tick(1);
    ordy[k] = 1'b0;
  endtask

  int vals[4] = '{100, -30, 7, 1};

  initial begin
    rst_n = 1'b0;
    tick(2);
    cmp_en = 1'b1;
    check("reset_in_ready", longint'(ir[0]), 0);
    check("reset_out_data", longint'(od0), 0);
    rst_n = 1'b1;
    tick(1);
    check("idle_in_ready", longint'(ir[0]), 1);

    // Back-to-back sum.
    for (int i = 0; i < 4; i++) begin
      check("b2b_no_early_valid", longint'(ov[0]), 0);
      send(0, vals[i]);
    end
    check("b2b_valid", longint'(ov[0]), 1);
    check("b2b_data", longint'(od0), 78);
    check("b2b_ovf", longint'(ovf[0]), 0);
    accept(0);

    // Same sum with bubbles, then a held result.
    for (int i = 0; i < 4; i++) begin
      send(0, vals[i]);
      if (i < 3) begin
        check("bub_no_valid", longint'(ov[0]), 0);
        tick(3);
      end
    end
    check("bub_valid", longint'(ov[0]), 1);
    check("bub_data", longint'(od0), 78);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("hold_valid", longint'(ov[0]), 1);
      check("hold_data", longint'(od0), 78);
      check("hold_in_ready", longint'(ir[0]), 0);
    end
    accept(0);
    check("post_accept_in_ready", longint'(ir[0]), 1);
    check("post_accept_valid", longint'(ov[0]), 0);
    check("post_accept_data", longint'(od0), 0);

    // Overflow on the 20-bit, 8-term configuration.
    for (int i = 0; i < 8; i++) send(2, 131071);
    check("ovf_valid", longint'(ov[2]), 1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    check("ovf_data_sat", longint'(od2), 524287);
`else
    check("ovf_data_wrap", longint'(od2), -8);
`endif
    check("ovf_flag", longint'(ovf[2]), 1);
    accept(2);

    // Reset discards a partial sum.
    send(0, 1000);
    send(0, 2000);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rst_no_early_valid", longint'(ov[0]), 0);
      send(0, 5);
    end
    check("rst_valid", longint'(ov[0]), 1);
    check("rst_data", longint'(od0), 20);
    accept(0);

    // Single-term configuration.
    send(1, -42);
    check("n1_valid", longint'(ov[1]), 1);
    check("n1_data", longint'(od1), -42);
    check("n1_in_ready", longint'(ir[1]), 0);
    tick(2);
    check("n1_in_ready_held", longint'(ir[1]), 0);
    accept(1);
    check("n1_in_ready_after", longint'(ir[1]), 1);

    // Random traffic with bubbles, back-pressure and occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < NDUT; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        id[k]   = 18'($urandom_range(0, 262143));
        ordy[k] = ($urandom_range(0, 2) == 0);
      end
      rst_n = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    for (int k = 0; k < NDUT; k++) begin iv[k] = 1'b0; ordy[k] = 1'b0; end
    rst_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
